// File: rtl/ken_sprite_addr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : ken_sprite_addr_gen_if
//  Description : Signal bundle between the scan/position source and the Ken
//                sprite address generator.
//                master : drives frame_clk, DrawX/DrawY, PosX/PosY,
//                         facing_left, anim_start; receives results.
//                slave  : the address generator; receives the scan and
//                         sprite inputs, drives anim_busy, frame_idx,
//                         address and in_sprite.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ken_sprite_addr_gen_if #(
    parameter int ADDR_W = 19,
    parameter int FIDX_W = 2
);
    logic              frame_clk;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        PosX;
    logic [9:0]        PosY;
    logic              facing_left;
    logic              anim_start;
    logic              anim_busy;
    logic [FIDX_W-1:0] frame_idx;
    logic [ADDR_W-1:0] address;
    logic              in_sprite;

    modport master (
        output frame_clk, DrawX, DrawY, PosX, PosY, facing_left, anim_start,
        input  anim_busy, frame_idx, address, in_sprite
    );

    modport slave (
        input  frame_clk, DrawX, DrawY, PosX, PosY, facing_left, anim_start,
        output anim_busy, frame_idx, address, in_sprite
    );
endinterface
`default_nettype wire

// File: rtl/ken_sprite_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ken_sprite_addr_gen
//  Description : Converts the VGA scan position and Ken's screen position
//                into a sprite-sheet ROM address, runs the one-shot move
//                animation that picks the sheet frame, applies horizontal
//                flip for facing direction, and produces an in-sprite flag
//                aligned with the colour mapper's registered outputs.
//  Ports       : Clk   - pixel clock
//                Reset - synchronous active-high reset
//                bus   - slave side of ken_sprite_addr_gen_if
//                        (frame_clk, DrawX/Y, PosX/Y, facing_left,
//                         anim_start in; anim_busy, frame_idx, address,
//                         in_sprite out)
//  Revision    : 1.0 - initial release
// ============================================================================
module ken_sprite_addr_gen #(
    parameter int SPR_W      = 96,
    parameter int SPR_H      = 112,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    parameter int ADDR_W     = 19
) (
    input  wire logic           Clk,
    input  wire logic           Reset,
    ken_sprite_addr_gen_if.slave bus
);

    localparam int c_SHEET_W = SPR_W * NUM_FRAMES;
    localparam int c_FIDX_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int c_HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST  = c_HOLD_W'(FRAME_HOLD - 1);
    localparam logic [c_FIDX_W-1:0] c_FRAME_LAST = c_FIDX_W'(NUM_FRAMES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [c_FIDX_W-1:0] r_frame_idx;
    logic [c_FIDX_W-1:0] w_frame_idx_nxt;

    logic                r_fc_d;
    logic                w_fc_rise;
    logic                r_facing;

    logic [10:0]         w_dx;
    logic [10:0]         w_dy;
    logic [10:0]         w_px;
    logic [10:0]         w_py;
    logic [10:0]         w_x_end;
    logic [10:0]         w_y_end;
    logic [10:0]         w_col;
    logic [10:0]         w_row;
    logic [10:0]         w_col_eff;
    logic                w_inside;
    logic [ADDR_W-1:0]   w_addr_sum;

    logic [ADDR_W-1:0]   r_address;
    logic                r_inside_d1;
    logic                r_in_sprite;

    // ------------------------------------------------------------------
    // frame_clk edge detect and facing latch. Facing only changes on a
    // vsync edge so a mirror flip never lands mid-frame.
    // ------------------------------------------------------------------
    assign w_fc_rise = bus.frame_clk & ~r_fc_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fc_d   <= 1'b0;
            r_facing <= 1'b0;
        end else begin
            r_fc_d <= bus.frame_clk;
            if (w_fc_rise) begin
                r_facing <= bus.facing_left;
            end
        end
    end

    // ------------------------------------------------------------------
    // Animation sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_frame_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_frame_idx <= w_frame_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Animation sequencer: next state. Requests while playing are dropped,
    // including one coinciding with the final advance.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold;
        w_frame_idx_nxt = r_frame_idx;
        case (r_state)
            S_IDLE: begin
                w_hold_nxt      = '0;
                w_frame_idx_nxt = '0;
                if (bus.anim_start) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_fc_rise) begin
                    if (r_hold == c_HOLD_LAST) begin
                        w_hold_nxt = '0;
                        if (r_frame_idx == c_FRAME_LAST) begin
                            w_state_nxt     = S_IDLE;
                            w_frame_idx_nxt = '0;
                        end else begin
                            w_frame_idx_nxt = r_frame_idx + 1'b1;
                        end
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_hold_nxt      = '0;
                w_frame_idx_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Box test and address. One extra bit keeps PosX+SPR_W from wrapping
    // near the right edge of the 10-bit coordinate space.
    // ------------------------------------------------------------------
    assign w_dx    = {1'b0, bus.DrawX};
    assign w_dy    = {1'b0, bus.DrawY};
    assign w_px    = {1'b0, bus.PosX};
    assign w_py    = {1'b0, bus.PosY};
    assign w_x_end = w_px + 11'(SPR_W);
    assign w_y_end = w_py + 11'(SPR_H);

    assign w_inside = (w_dx >= w_px) && (w_dx < w_x_end) &&
                      (w_dy >= w_py) && (w_dy < w_y_end);

    assign w_col     = w_dx - w_px;
    assign w_row     = w_dy - w_py;
    assign w_col_eff = r_facing ? (11'(SPR_W - 1) - w_col) : w_col;

    // Frames sit side by side, so one sheet row spans all frames.
    assign w_addr_sum = ADDR_W'(w_row) * ADDR_W'(c_SHEET_W)
                      + ADDR_W'(r_frame_idx) * ADDR_W'(SPR_W)
                      + ADDR_W'(w_col_eff);

    // ------------------------------------------------------------------
    // Output pipeline: address one cycle behind the scan position; the
    // in-sprite flag takes a second stage to match the mapper's register.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_address   <= '0;
            r_inside_d1 <= 1'b0;
            r_in_sprite <= 1'b0;
        end else begin
            r_address   <= w_inside ? w_addr_sum : '0;
            r_inside_d1 <= w_inside;
            r_in_sprite <= r_inside_d1;
        end
    end

    assign bus.address   = r_address;
    assign bus.in_sprite = r_in_sprite;
    assign bus.anim_busy = (r_state == S_PLAY);
    assign bus.frame_idx = r_frame_idx;

endmodule
`default_nettype wire

// File: tb/tb_ken_sprite_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ken_sprite_addr_gen
//  Description : Self-checking bench for ken_sprite_addr_gen. A behavioural
//                model counts vsync edges since the animation began and
//                computes box/address with integer arithmetic; every cycle
//                after the first reset the DUT outputs are compared against
//                it. Directed literal expectations pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ken_sprite_addr_gen;

    localparam int SPR_W   = 96;
    localparam int SPR_H   = 112;
    localparam int NF      = 4;
    localparam int HOLD    = 2;
    localparam int AW      = 19;
    localparam int SHEET_W = SPR_W * NF;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    ken_sprite_addr_gen_if #(.ADDR_W(AW), .FIDX_W(2)) bus ();

    ken_sprite_addr_gen #(
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .NUM_FRAMES (NF),
        .FRAME_HOLD (HOLD),
        .ADDR_W     (AW)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic bit f_inside(input int dx, input int dy, input int px, input int py);
        return (dx >= px) && (dx < px + SPR_W) && (dy >= py) && (dy < py + SPR_H);
    endfunction

    function automatic int f_addr(input int dx, input int dy, input int px, input int py,
                                  input int frame, input bit flip);
        int col;
        col = dx - px;
        if (flip) col = SPR_W - 1 - col;
        if (!f_inside(dx, dy, px, py)) return 0;
        return ((dy - py) * SHEET_W + frame * SPR_W + col) % (1 << AW);
    endfunction

    bit m_valid = 1'b0;
    bit m_fc_d, m_facing, m_busy, m_ins1, m_ins2;
    int m_edges, m_addr;
    int m_frame;

    // Frame shown = completed vsync edges since start / HOLD
    assign m_frame = m_busy ? (m_edges / HOLD) : 0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_valid  <= 1'b1;
            m_fc_d   <= 1'b0;
            m_facing <= 1'b0;
            m_busy   <= 1'b0;
            m_edges  <= 0;
            m_addr   <= 0;
            m_ins1   <= 1'b0;
            m_ins2   <= 1'b0;
        end else begin
            m_fc_d <= bus.frame_clk;
            if (bus.frame_clk && !m_fc_d) m_facing <= bus.facing_left;
            if (!m_busy) begin
                if (bus.anim_start) begin
                    m_busy  <= 1'b1;
                    m_edges <= 0;
                end
            end else if (bus.frame_clk && !m_fc_d) begin
                if (m_edges + 1 == NF * HOLD) begin
                    m_busy  <= 1'b0;
                    m_edges <= 0;
                end else begin
                    m_edges <= m_edges + 1;
                end
            end
            m_addr <= f_addr(int'(bus.DrawX), int'(bus.DrawY), int'(bus.PosX), int'(bus.PosY),
                             m_frame, m_facing);
            m_ins1 <= f_inside(int'(bus.DrawX), int'(bus.DrawY), int'(bus.PosX), int'(bus.PosY));
            m_ins2 <= m_ins1;
        end
    end

    // Compare process: outputs settle after posedge, sampled on negedge
    always @(negedge Clk) begin
        if (m_valid) begin
            check("model_address",   32'(bus.address),   32'(m_addr));
            check("model_in_sprite", 32'(bus.in_sprite), 32'(m_ins2));
            check("model_anim_busy", 32'(bus.anim_busy), 32'(m_busy));
            check("model_frame_idx", 32'(bus.frame_idx), 32'(m_frame));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic fc_pulse();
        bus.frame_clk = 1'b1;
        repeat (2) tick();
        bus.frame_clk = 1'b0;
        repeat (2) tick();
    endtask

    task automatic set_pix(input int dx, input int dy, input int px, input int py);
        bus.DrawX = 10'(dx);
        bus.DrawY = 10'(dy);
        bus.PosX  = 10'(px);
        bus.PosY  = 10'(py);
    endtask

    initial begin
        bus.frame_clk   = 1'b0;
        bus.anim_start  = 1'b0;
        bus.facing_left = 1'($urandom);
        set_pix($urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023));

        // Reset with arbitrary inputs
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        check("rst_address",   32'(bus.address),   32'd0);
        check("rst_in_sprite", 32'(bus.in_sprite), 32'd0);
        check("rst_anim_busy", 32'(bus.anim_busy), 32'd0);
        check("rst_frame_idx", 32'(bus.frame_idx), 32'd0);

        // Basic address, frame 0, no flip
        bus.facing_left = 1'b0;
        set_pix(110, 205, 100, 200);
        tick();
        check("addr_basic", 32'(bus.address), 32'd1930);
        tick();
        check("insprite_basic", 32'(bus.in_sprite), 32'd1);

        // Flip latched by a vsync edge
        bus.facing_left = 1'b1;
        fc_pulse();
        check("addr_flip", 32'(bus.address), 32'd2005);

        // Right edge of the box
        set_pix(195, 205, 100, 200);
        repeat (2) tick();
        check("addr_col95_flip", 32'(bus.address),   32'd1920);
        check("insprite_col95",  32'(bus.in_sprite), 32'd1);
        set_pix(196, 205, 100, 200);
        tick();
        check("addr_col96", 32'(bus.address), 32'd0);
        tick();
        check("insprite_col96", 32'(bus.in_sprite), 32'd0);

        // Animation sequence, back to unflipped
        bus.facing_left = 1'b0;
        set_pix(110, 205, 100, 200);
        fc_pulse();
        bus.anim_start = 1'b1;
        tick();
        bus.anim_start = 1'b0;
        check("anim_busy_start",  32'(bus.anim_busy), 32'd1);
        check("anim_frame_start", 32'(bus.frame_idx), 32'd0);
        for (int e = 1; e <= 8; e++) begin
            fc_pulse();
            check("anim_frame", 32'(bus.frame_idx), (e < 8) ? 32'(e / 2) : 32'd0);
            check("anim_busy",  32'(bus.anim_busy), (e < 8) ? 32'd1 : 32'd0);
            if (e == 2) begin
                bus.anim_start = 1'b1;
                tick();
                bus.anim_start = 1'b0;
                check("ignored_start_frame", 32'(bus.frame_idx), 32'd1);
                check("ignored_start_busy",  32'(bus.anim_busy), 32'd1);
            end
            if (e == 4) begin
                check("addr_frame2", 32'(bus.address), 32'd2122);
            end
        end

        // Request coinciding with the final advance is dropped
        bus.anim_start = 1'b1;
        tick();
        bus.anim_start = 1'b0;
        repeat (7) fc_pulse();
        check("final_frame3", 32'(bus.frame_idx), 32'd3);
        bus.frame_clk  = 1'b1;
        bus.anim_start = 1'b1;
        tick();
        bus.anim_start = 1'b0;
        check("collide_busy",  32'(bus.anim_busy), 32'd0);
        check("collide_frame", 32'(bus.frame_idx), 32'd0);
        bus.frame_clk = 1'b0;
        repeat (3) tick();
        check("collide_stays_idle", 32'(bus.anim_busy), 32'd0);

        // Reset in the middle of an animation
        bus.anim_start = 1'b1;
        tick();
        bus.anim_start = 1'b0;
        repeat (4) fc_pulse();
        check("midrst_frame_before", 32'(bus.frame_idx), 32'd2);
        Reset = 1'b1;
        tick();
        check("midrst_frame",     32'(bus.frame_idx), 32'd0);
        check("midrst_busy",      32'(bus.anim_busy), 32'd0);
        check("midrst_address",   32'(bus.address),   32'd0);
        check("midrst_in_sprite", 32'(bus.in_sprite), 32'd0);
        Reset = 1'b0;
        tick();

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            int px, py, x, y;
            if (i % 64 == 0) begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
                bus.PosX = 10'(px);
                bus.PosY = 10'(py);
            end
            x = int'(bus.PosX) + $urandom_range(0, SPR_W + 16) - 8;
            y = int'(bus.PosY) + $urandom_range(0, SPR_H + 16) - 8;
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            bus.DrawX = 10'(x);
            bus.DrawY = 10'(y);
            if ($urandom_range(0, 7) == 0) bus.frame_clk = ~bus.frame_clk;
            bus.anim_start  = ($urandom_range(0, 29) == 0);
            bus.facing_left = 1'($urandom);
            Reset           = ($urandom_range(0, 499) == 0);
            tick();
        end
        Reset = 1'b0;
        bus.anim_start = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
